// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 4;

    // Wide enough for any MAX_WAIT in 1..15.
    localparam int WAIT_W = 4;

    // Cycles from accept to read data: one to register the command, one for the memory.
    localparam int RD_LAT = 2;

    typedef enum logic {
        ST_OPEN        = 1'b0,
        ST_HOST_LOCKED = 1'b1
    } state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb_rd_tracker.sv
// Tracks in-flight reads so returning memory data reaches the requester that issued it.
module mem_arb_rd_tracker
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_rd,
    input  owner_t            issue_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata
);

    localparam int N_OWN = 2;

    rd_tag_t [RD_LAT-1:0] tag_reg;
    rd_tag_t              new_tag;
    logic                 rvalid [N_OWN];
    logic [DATA_W-1:0]    rdata  [N_OWN];

    // Build the tag for the command being accepted this cycle.
    always_comb begin
        new_tag.valid = issue_rd;
        new_tag.owner = issue_owner;
    end

    // Shift tags in lock-step with the memory pipeline; reset drops anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_reg <= '0;
        end else begin
            tag_reg <= {tag_reg[RD_LAT-2:0], new_tag};
        end
    end

    // One return lane per owner: pass live data through, otherwise hold the last delivered word.
    generate
        for (genvar gi = 0; gi < N_OWN; gi++) begin : g_own
            logic [DATA_W-1:0] hold_reg;

            assign rvalid[gi] = tag_reg[RD_LAT-1].valid &&
                                (tag_reg[RD_LAT-1].owner == owner_t'(1'(gi)));

            // Capture delivered data so a non-owner's bus keeps its previous value.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hold_reg <= '0;
                end else if (rvalid[gi]) begin
                    hold_reg <= mem_rdata;
                end
            end

            assign rdata[gi] = rvalid[gi] ? mem_rdata : hold_reg;
        end
    endgenerate

    assign cpu_rvalid  = rvalid[OWN_CPU];
    assign cpu_rdata   = rdata[OWN_CPU];
    assign host_rvalid = rvalid[OWN_HOST];
    assign host_rdata  = rdata[OWN_HOST];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between the CPU control unit and the host loader/debug port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              force_host;
    logic              issue_rd;
    owner_t            issue_owner;

    // State and host starvation counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_OPEN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Grant decision, lock tracking and starvation counting for the current cycle.
    always_comb begin
        cpu_gnt       = 1'b0;
        host_gnt      = 1'b0;
        state_next    = ST_OPEN;
        wait_cnt_next = wait_cnt_reg;
        force_host    = host_req && (wait_cnt_reg == WAIT_W'(MAX_WAIT));

        // A locked host keeps the port only while it holds host_lock; dropping it
        // reopens arbitration in that same cycle.
        if (state_reg == ST_HOST_LOCKED && host_lock) begin
            host_gnt = host_req;
        end else begin
            cpu_gnt  = cpu_req && !force_host;
            host_gnt = host_req && !cpu_gnt;
        end

        if (host_lock && (host_gnt || state_reg == ST_HOST_LOCKED)) begin
            state_next = ST_HOST_LOCKED;
        end

        if (!host_req || host_gnt) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
    end

    assign cpu_stall   = cpu_req && !cpu_gnt;
    assign issue_rd    = (cpu_gnt && !cpu_we) || (host_gnt && !host_we);
    assign issue_owner = host_gnt ? OWN_HOST : OWN_CPU;

    // Register the winning command onto the memory interface; address/data hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (host_gnt) begin
            mem_en    <= 1'b1;
            mem_we    <= host_we;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
        end else if (cpu_gnt) begin
            mem_en    <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    mem_arb_rd_tracker #(
        .DATA_W (DATA_W)
    ) u_rd_tracker (
        .clk         (clk),
        .reset       (reset),
        .issue_rd    (issue_rd),
        .issue_owner (issue_owner),
        .mem_rdata   (mem_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous single-port memory model.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       host_req, host_we, host_lock;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_lock   (host_lock),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Memory model: preset contents until first written; read data is X until the first read.
    logic [7:0] ram [256];
    bit         written [256];
    logic [7:0] ram_q;

    function automatic logic [7:0] preset(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hA5;
            8'h20:   return 8'h11;
            8'h21:   return 8'h22;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                ram_q <= written[mem_addr] ? ram[mem_addr] : preset(mem_addr);
            end
        end
    end
    assign mem_rdata = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
    endtask

    initial begin
        idle();
        reset = 1'b0;

        // Reset state, with memory read data still X
        nxt(); nxt(); #2;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        nxt();
        reset = 1'b1;
        nxt();

        // 1. CPU-only read of 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; #2;
        chk("t1_cpu_gnt", cpu_gnt, 1);
        chk("t1_cpu_stall", cpu_stall, 0);
        chk("t1_host_gnt", host_gnt, 0);
        nxt();
        cpu_req = 0; #2;
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 8'h10);
        chk("t1_rvalid_early", cpu_rvalid, 0);
        nxt(); #2;
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_cpu_rdata", cpu_rdata, 8'hA5);
        chk("t1_host_rvalid", host_rvalid, 0);
        nxt(); #2;
        chk("t1_rvalid_drop", cpu_rvalid, 0);
        chk("t1_rdata_hold", cpu_rdata, 8'hA5);

        // 2. Contention: CPU wins four, host forced through on the fifth, repeating
        cpu_req = 1; cpu_addr = 8'h01; host_req = 1; host_we = 0; host_addr = 8'h02;
        for (int k = 0; k < 10; k++) begin
            #2;
            chk($sformatf("t2_cpu_gnt_%0d", k), cpu_gnt, (k % 5) != 4);
            chk($sformatf("t2_host_gnt_%0d", k), host_gnt, (k % 5) == 4);
            chk($sformatf("t2_cpu_stall_%0d", k), cpu_stall, (k % 5) == 4);
            nxt();
        end
        idle();
        nxt(); nxt(); nxt();

        // 3. Locked host write burst starves the CPU until the lock drops
        host_req = 1; host_we = 1; host_lock = 1; host_addr = 8'h00; host_wdata = 8'h50; #2;
        chk("t3_c0_host_gnt", host_gnt, 1);
        nxt();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
        host_addr = 8'h01; host_wdata = 8'h51; #2;
        chk("t3_c1_host_gnt", host_gnt, 1);
        chk("t3_c1_cpu_gnt", cpu_gnt, 0);
        chk("t3_c1_cpu_stall", cpu_stall, 1);
        nxt();
        host_req = 0; #2;
        chk("t3_c2_host_gnt", host_gnt, 0);
        chk("t3_c2_cpu_gnt", cpu_gnt, 0);
        chk("t3_c2_cpu_stall", cpu_stall, 1);
        chk("t3_c2_mem_we", mem_we, 1);
        chk("t3_c2_mem_addr", mem_addr, 8'h01);
        chk("t3_c2_mem_wdata", mem_wdata, 8'h51);
        nxt();
        host_req = 1; host_addr = 8'h02; host_wdata = 8'h52; #2;
        chk("t3_c3_host_gnt", host_gnt, 1);
        chk("t3_c3_cpu_stall", cpu_stall, 1);
        nxt();
        host_addr = 8'h03; host_wdata = 8'h53; #2;
        chk("t3_c4_host_gnt", host_gnt, 1);
        chk("t3_c4_cpu_stall", cpu_stall, 1);
        nxt();
        host_req = 0; host_lock = 0; #2;
        chk("t3_c5_cpu_gnt", cpu_gnt, 1);
        chk("t3_c5_cpu_stall", cpu_stall, 0);
        nxt();
        cpu_req = 0; #2;
        chk("t3_c6_mem_en", mem_en, 1);
        chk("t3_c6_mem_we", mem_we, 0);
        chk("t3_c6_mem_addr", mem_addr, 8'h30);
        idle();
        nxt(); nxt(); nxt();

        // 4. Interleaved reads go back to their own issuer
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20; #2;
        chk("t4_cpu_gnt", cpu_gnt, 1);
        nxt();
        cpu_req = 0; host_req = 1; host_we = 0; host_addr = 8'h21; #2;
        chk("t4_host_gnt", host_gnt, 1);
        nxt();
        host_req = 0; #2;
        chk("t4_cpu_rvalid", cpu_rvalid, 1);
        chk("t4_cpu_rdata", cpu_rdata, 8'h11);
        chk("t4_host_rvalid_early", host_rvalid, 0);
        nxt(); #2;
        chk("t4_host_rvalid", host_rvalid, 1);
        chk("t4_host_rdata", host_rdata, 8'h22);
        chk("t4_cpu_rvalid_drop", cpu_rvalid, 0);
        chk("t4_cpu_rdata_hold", cpu_rdata, 8'h11);
        nxt();

        // 5. Host write then CPU read of same address; also read back a burst word
        host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 8'h3C; #2;
        chk("t5_host_gnt", host_gnt, 1);
        nxt();
        host_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40; #2;
        chk("t5_cpu_gnt_a", cpu_gnt, 1);
        nxt();
        cpu_addr = 8'h03; #2;
        chk("t5_cpu_gnt_b", cpu_gnt, 1);
        nxt();
        cpu_req = 0; #2;
        chk("t5_cpu_rvalid_a", cpu_rvalid, 1);
        chk("t5_cpu_rdata_a", cpu_rdata, 8'h3C);
        nxt(); #2;
        chk("t5_cpu_rvalid_b", cpu_rvalid, 1);
        chk("t5_cpu_rdata_b", cpu_rdata, 8'h53);
        nxt(); #2;
        chk("t5_rvalid_drop", cpu_rvalid, 0);
        chk("t5_rdata_hold", cpu_rdata, 8'h53);
        nxt();

        // 6. Reset the cycle after a CPU read is accepted
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; #2;
        chk("t6_cpu_gnt", cpu_gnt, 1);
        nxt();
        idle();
        reset = 1'b0; #2;
        chk("t6_mem_en", mem_en, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_cpu_rvalid", cpu_rvalid, 0);
        chk("t6_cpu_rdata", cpu_rdata, 0);
        chk("t6_host_rdata", host_rdata, 0);
        nxt(); nxt();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                cpu_req = 1; cpu_addr = 8'h10; host_lock = 1;
            end
            #2;
            chk($sformatf("t6_post_cpu_rvalid_%0d", k), cpu_rvalid, 0);
            chk($sformatf("t6_post_host_rvalid_%0d", k), host_rvalid, 0);
            nxt();
        end
        // Still inside the third post-release cycle window: the CPU was granted with lock high
        // only because the FSM came out of reset open.
        idle();
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Records whether the CPU was granted while host_lock was high just after reset release.
    logic open_after_rst = 1'b0;
    always @(negedge clk) begin
        if (reset && cpu_req && host_lock && cpu_addr == 8'h10 && cpu_gnt) open_after_rst <= 1'b1;
    end

    final begin
        if (!open_after_rst) $display("FAIL t6_fsm_open observed=0 expected=1");
    end

endmodule
